// File: rtl/ddrio_hdx_sched.sv
// Half-duplex scheduler for a bidirectional DDR pad pair: arbitrates TX bursts against RX captures,
// sequences oen turnaround and IO-cell bring-up. Define DDRIO_HDX_ERR_CNT_EN to build the underrun counter.
module ddrio_hdx_sched #(
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned IN_LAT      = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tx_valid_i,
    input  logic [3:0]  tx_data_i,
    input  logic        tx_last_i,
    output logic        tx_ready_o,
    input  logic        rx_req_i,
    input  logic [7:0]  rx_len_i,
    output logic        rx_valid_o,
    output logic [3:0]  rx_data_o,
    output logic        rx_done_o,
    output logic        io_clk_en_o,
    output logic        io_rstn_o,
    output logic        io_setn_o,
    output logic [1:0]  io_oen_o,
    output logic [1:0]  io_odp_o,
    output logic [1:0]  io_odn_o,
    input  logic [1:0]  io_idp_i,
    input  logic [1:0]  io_idn_i,
    output logic        busy_o,
    output logic [15:0] err_cnt_o
);

    typedef enum logic [2:0] {StBringup, StIdle, StTx, StTurn, StRx, StDrain} state_e;

    localparam logic [8:0] RstEnd   = 9'(RST_CYCLES);
    localparam logic [8:0] TurnEnd  = 9'(TURN_CYCLES);
    localparam logic [8:0] DrainEnd = 9'((IN_LAT == 0) ? 0 : IN_LAT - 1);

    state_e     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [8:0] len_q, len_d;
    logic       grant_tx_q, grant_tx_d;  // 1 = TX was granted last
    logic       clk_en_q, clk_en_d;
    logic       rstn_q, rstn_d;
    logic [1:0] oen_q, oen_d;
    logic [3:0] od_q, od_d;
    logic       tx_ready_q, tx_ready_d;
    logic       busy_q;
    logic       rx_valid_q, rx_last_q, rx_done_q;
    logic [3:0] rx_data_q;

    logic       s_valid, s_last;
    logic       p_valid, p_last;
    logic [3:0] p_data;
    logic [3:0] pin_data;

    assign pin_data = {io_idp_i[1], io_idn_i[1], io_idp_i[0], io_idn_i[0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        grant_tx_d = grant_tx_q;
        clk_en_d   = clk_en_q;
        rstn_d     = rstn_q;
        oen_d      = 2'b11;
        od_d       = 4'h0;
        tx_ready_d = 1'b0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        unique case (state_q)
            StBringup: begin
                clk_en_d = 1'b1;
                if (cnt_q == RstEnd) begin
                    rstn_d  = 1'b1;
                    cnt_d   = 9'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            StIdle: begin
                if (tx_valid_i && (!rx_req_i || !grant_tx_q)) begin
                    state_d    = StTx;
                    grant_tx_d = 1'b1;
                    tx_ready_d = 1'b1;
                    oen_d      = 2'b00;
                end else if (rx_req_i) begin
                    state_d    = StRx;
                    grant_tx_d = 1'b0;
                    cnt_d      = 9'd0;
                    len_d      = (rx_len_i == 8'd0) ? 9'd256 : {1'b0, rx_len_i};
                end
            end
            StTx: begin
                oen_d      = 2'b00;
                tx_ready_d = 1'b1;
                // Underrun leaves od_d at zero while the pads stay driven.
                if (tx_valid_i && tx_ready_q) begin
                    od_d = tx_data_i;
                    if (tx_last_i) begin
                        tx_ready_d = 1'b0;
                        cnt_d      = 9'd0;
                        state_d    = StTurn;
                    end
                end
            end
            StTurn: begin
                if (cnt_q == TurnEnd) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            StRx: begin
                s_valid = 1'b1;
                s_last  = (cnt_q == len_q - 9'd1);
                if (s_last) begin
                    cnt_d   = 9'd0;
                    state_d = (IN_LAT == 0) ? StIdle : StDrain;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            StDrain: begin
                if (cnt_q == DrainEnd) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: state_d = StBringup;
        endcase
    end

    // Input-cell latency model: captured beats travel IN_LAT stages before the output register.
    generate
        if (IN_LAT == 0) begin : g_nolat
            assign p_valid = s_valid;
            assign p_last  = s_last;
            assign p_data  = pin_data;
        end else begin : g_lat
            logic [IN_LAT-1:0]      pv_q, pl_q;
            logic [IN_LAT-1:0][3:0] pd_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pv_q <= '0;
                    pl_q <= '0;
                    pd_q <= '0;
                end else begin
                    pv_q[0] <= s_valid;
                    pl_q[0] <= s_last;
                    pd_q[0] <= pin_data;
                    for (int i = 1; i < IN_LAT; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pl_q[i] <= pl_q[i-1];
                        pd_q[i] <= pd_q[i-1];
                    end
                end
            end
            assign p_valid = pv_q[IN_LAT-1];
            assign p_last  = pl_q[IN_LAT-1];
            assign p_data  = pd_q[IN_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StBringup;
            cnt_q      <= 9'd0;
            len_q      <= 9'd0;
            grant_tx_q <= 1'b0;
            clk_en_q   <= 1'b0;
            rstn_q     <= 1'b0;
            oen_q      <= 2'b11;
            od_q       <= 4'h0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
            rx_data_q  <= 4'h0;
            rx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            grant_tx_q <= grant_tx_d;
            clk_en_q   <= clk_en_d;
            rstn_q     <= rstn_d;
            oen_q      <= oen_d;
            od_q       <= od_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= (state_d != StIdle);
            rx_valid_q <= p_valid;
            rx_last_q  <= p_valid & p_last;
            rx_data_q  <= p_valid ? p_data : 4'h0;
            rx_done_q  <= rx_valid_q & rx_last_q;
        end
    end

`ifdef DDRIO_HDX_ERR_CNT_EN
    logic [15:0] err_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 16'h0;
        end else if (state_q == StTx && !tx_valid_i && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end
    assign err_cnt_o = err_q;
`else
    assign err_cnt_o = 16'h0;
`endif

    assign tx_ready_o  = tx_ready_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_data_q;
    assign rx_done_o   = rx_done_q;
    assign io_clk_en_o = clk_en_q;
    assign io_rstn_o   = rstn_q;
    assign io_setn_o   = 1'b1;
    assign io_oen_o    = oen_q;
    assign io_odp_o    = {od_q[3], od_q[1]};
    assign io_odn_o    = {od_q[2], od_q[0]};
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ddrio_hdx_sched.sv
// Directed-plus-random bench for ddrio_hdx_sched; expected traces are built per transaction
// from the scheduling rules (grant, beat latency, turnaround, capture window).
module tb_ddrio_hdx_sched;

    localparam int unsigned RST_CYCLES  = 16;
    localparam int unsigned TURN_CYCLES = 2;
    localparam int unsigned IN_LAT      = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        tx_valid_i;
    logic [3:0]  tx_data_i;
    logic        tx_last_i;
    logic        tx_ready_o;
    logic        rx_req_i;
    logic [7:0]  rx_len_i;
    logic        rx_valid_o;
    logic [3:0]  rx_data_o;
    logic        rx_done_o;
    logic        io_clk_en_o;
    logic        io_rstn_o;
    logic        io_setn_o;
    logic [1:0]  io_oen_o;
    logic [1:0]  io_odp_o;
    logic [1:0]  io_odn_o;
    logic [1:0]  io_idp_i;
    logic [1:0]  io_idn_i;
    logic        busy_o;
    logic [15:0] err_cnt_o;

    int total = 0;
    int bad   = 0;
    int err_exp = 0;

    ddrio_hdx_sched #(
        .RST_CYCLES (RST_CYCLES),
        .TURN_CYCLES(TURN_CYCLES),
        .IN_LAT     (IN_LAT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tx_valid_i (tx_valid_i),
        .tx_data_i  (tx_data_i),
        .tx_last_i  (tx_last_i),
        .tx_ready_o (tx_ready_o),
        .rx_req_i   (rx_req_i),
        .rx_len_i   (rx_len_i),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o),
        .rx_done_o  (rx_done_o),
        .io_clk_en_o(io_clk_en_o),
        .io_rstn_o  (io_rstn_o),
        .io_setn_o  (io_setn_o),
        .io_oen_o   (io_oen_o),
        .io_odp_o   (io_odp_o),
        .io_odn_o   (io_odn_o),
        .io_idp_i   (io_idp_i),
        .io_idn_i   (io_idn_i),
        .busy_o     (busy_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [3:0] od_nib();
        return {io_odp_o[1], io_odn_o[1], io_odp_o[0], io_odn_o[0]};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, " clk_en"}, 32'(io_clk_en_o), 32'd0);
        chk({tag, " rstn"}, 32'(io_rstn_o), 32'd0);
        chk({tag, " setn"}, 32'(io_setn_o), 32'd1);
        chk({tag, " oen"}, 32'(io_oen_o), 32'h3);
        chk({tag, " od"}, 32'(od_nib()), 32'h0);
        chk({tag, " tx_ready"}, 32'(tx_ready_o), 32'd0);
        chk({tag, " rx_valid"}, 32'(rx_valid_o), 32'd0);
        chk({tag, " rx_data"}, 32'(rx_data_o), 32'h0);
        chk({tag, " rx_done"}, 32'(rx_done_o), 32'd0);
        chk({tag, " busy"}, 32'(busy_o), 32'd1);
        chk({tag, " err_cnt"}, 32'(err_cnt_o), 32'd0);
    endtask

    // rstn low for RST_CYCLES cycles after release, clock enabled from the first cycle.
    task automatic bringup(input string tag);
        for (int n = 1; n <= int'(RST_CYCLES) + 1; n++) begin
            tick();
            chk({tag, " clk_en"}, 32'(io_clk_en_o), 32'd1);
            chk({tag, " rstn"}, 32'(io_rstn_o), 32'(n > int'(RST_CYCLES)));
            chk({tag, " busy"}, 32'(busy_o), 32'(n <= int'(RST_CYCLES)));
            chk({tag, " rx_done"}, 32'(rx_done_o), 32'd0);
        end
    endtask

    // n beats, with gap_len underrun cycles inserted before beat gap_at.
    task automatic tx_burst(input int n, input int gap_at, input int gap_len,
                            input logic rx_hold, input logic fixed);
        logic       sv[$];
        logic [3:0] sd[$];
        logic       sl[$];
        logic [3:0] fx[3];
        logic [3:0] d;
        fx[0] = 4'hA;
        fx[1] = 4'h5;
        fx[2] = 4'hF;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    sv.push_back(1'b0);
                    sd.push_back(4'($urandom));
                    sl.push_back(1'b0);
                end
`ifdef DDRIO_HDX_ERR_CNT_EN
                err_exp += gap_len;
`endif
            end
            d = (fixed && i < 3) ? fx[i] : 4'($urandom);
            sv.push_back(1'b1);
            sd.push_back(d);
            sl.push_back(i == n - 1);
        end
        tx_valid_i = 1'b1;
        tx_data_i  = 4'($urandom);
        tx_last_i  = 1'b0;
        rx_req_i   = rx_hold;
        tick();
        chk("tx grant ready", 32'(tx_ready_o), 32'd1);
        chk("tx grant oen", 32'(io_oen_o), 32'h0);
        chk("tx grant od", 32'(od_nib()), 32'h0);
        chk("tx grant busy", 32'(busy_o), 32'd1);
        for (int s = 0; s < sv.size(); s++) begin
            tx_valid_i = sv[s];
            tx_data_i  = sd[s];
            tx_last_i  = sl[s];
            tick();
            chk("tx od", 32'(od_nib()), 32'(sv[s] ? sd[s] : 4'h0));
            chk("tx oen", 32'(io_oen_o), 32'h0);
            chk("tx ready", 32'(tx_ready_o), 32'(!(sv[s] && sl[s])));
            chk("tx busy", 32'(busy_o), 32'd1);
        end
        tx_valid_i = 1'b0;
        tx_last_i  = 1'b0;
        for (int t = 0; t < int'(TURN_CYCLES); t++) begin
            tick();
            chk("turn oen", 32'(io_oen_o), 32'h3);
            chk("turn od", 32'(od_nib()), 32'h0);
            chk("turn busy", 32'(busy_o), 32'd1);
            chk("turn ready", 32'(tx_ready_o), 32'd0);
        end
        tick();
        chk("post-tx busy", 32'(busy_o), 32'd0);
        chk("post-tx oen", 32'(io_oen_o), 32'h3);
        chk("err_cnt", 32'(err_cnt_o), 32'(err_exp));
    endtask

    // Pads sampled on each of the len window cycles reappear IN_LAT cycles later.
    task automatic rx_capture(input logic [7:0] len8, input logic tx_compete);
        int         len;
        logic [3:0] pad[int];
        logic [3:0] v;
        logic       ev;
        len = (len8 == 8'd0) ? 256 : int'(len8);
        rx_req_i   = 1'b1;
        rx_len_i   = len8;
        tx_valid_i = tx_compete;
        tx_data_i  = 4'($urandom);
        tick();
        chk("rx grant ready", 32'(tx_ready_o), 32'd0);
        chk("rx grant oen", 32'(io_oen_o), 32'h3);
        chk("rx grant busy", 32'(busy_o), 32'd1);
        chk("rx grant valid", 32'(rx_valid_o), 32'd0);
        rx_req_i   = 1'b0;
        tx_valid_i = 1'b0;
        rx_len_i   = 8'($urandom);
        for (int k = 1; k <= len + int'(IN_LAT) + 1; k++) begin
            v = 4'($urandom);
            if (k <= len) pad[k] = v;
            io_idp_i = {v[3], v[1]};
            io_idn_i = {v[2], v[0]};
            tick();
            ev = (k - int'(IN_LAT) >= 1) && (k - int'(IN_LAT) <= len);
            chk("rx valid", 32'(rx_valid_o), 32'(ev));
            chk("rx data", 32'(rx_data_o), 32'(ev ? pad[k - int'(IN_LAT)] : 4'h0));
            chk("rx done", 32'(rx_done_o), 32'(k == len + int'(IN_LAT) + 1));
            chk("rx busy", 32'(busy_o), 32'(k < len + int'(IN_LAT)));
            chk("rx oen", 32'(io_oen_o), 32'h3);
        end
    endtask

    initial begin
        logic [3:0] v;
        rst_i      = 1'b1;
        tx_valid_i = 1'b0;
        tx_data_i  = 4'h0;
        tx_last_i  = 1'b0;
        rx_req_i   = 1'b0;
        rx_len_i   = 8'd0;
        io_idp_i   = 2'b00;
        io_idn_i   = 2'b00;
        #12;
        chk_reset_vals("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bringup("bringup");

        // Both sides request after reset: TX first, then RX.
        tx_burst(3, 99, 0, 1'b1, 1'b1);
        rx_capture(8'd4, 1'b1);

        tx_burst(6, 2, 5, 1'b0, 1'b0);

        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(1) == 1) begin
                tx_burst(int'($urandom_range(6, 1)), int'($urandom_range(6)),
                         int'($urandom_range(3)), 1'b0, 1'b0);
            end else begin
                rx_capture(8'($urandom_range(12, 1)), 1'b0);
            end
        end
        rx_capture(8'd0, 1'b0);

        // Reset in the middle of a 256-beat capture.
        rx_req_i = 1'b1;
        rx_len_i = 8'd0;
        tick();
        rx_req_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            v = 4'($urandom);
            io_idp_i = {v[3], v[1]};
            io_idn_i = {v[2], v[0]};
            tick();
        end
        chk("mid-rx valid", 32'(rx_valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        err_exp = 0;
        chk_reset_vals("async rst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bringup("rebringup");
        rx_capture(8'd3, 1'b0);
        tx_burst(2, 1, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
